// File: rtl/multicycle_mips.sv
// multicycle_mips: multi-cycle MIPS-I subset core (CLK/RST, WE+W_Ins stream IMEM; PC, Result, Done retire pulse, Halt on illegal op)
module multicycle_mips #(
   parameter int          IMEM_DEPTH = 256,
   parameter int          DMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WE,
   input  logic [31:0] W_Ins,
   output logic [31:0] PC,
   output logic [31:0] Result,
   output logic        Done,
   output logic        Halt
);
   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);
   localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_SLT = 3'd4;
   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
   state_t state, next_state;
   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] dmem [DMEM_DEPTH];
   logic [31:0] rf [32];
   logic [31:0] ir, pc4, target, ra, rb, mdr, sext, alu_a, alu_b, alu_y;
   logic [IW-1:0] load_ptr;
   logic [5:0] op, funct;
   logic [4:0] dest;
   logic [2:0] alu_op;
   logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, legal, retire, run;
   assign op      = ir[31:26];
   assign funct   = ir[5:0];
   assign sext    = {{16{ir[15]}}, ir[15:0]};
   assign is_r    = op == 6'h00;
   assign is_addi = op == 6'h08;
   assign is_lw   = op == 6'h23;
   assign is_sw   = op == 6'h2B;
   assign is_beq  = op == 6'h04;
   assign is_j    = op == 6'h02;
   assign legal   = (is_r && funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) || is_addi || is_lw || is_sw || is_beq || is_j;
   assign dest    = is_r ? ir[15:11] : ir[20:16];
   assign run     = !RST && !WE;
   assign retire  = state == WRITEBACK || (state == MEMORY && is_sw) || (state == EXECUTE && (is_beq || is_j));
   assign Done    = run && retire;
   assign Halt    = state == HALT;
   // One adder/ALU serves PC+4 in FETCH, the branch target in DECODE and the instruction in EXECUTE.
   always_comb begin
      alu_a  = state == FETCH ? PC : state == DECODE ? pc4 : ra;
      alu_b  = state == FETCH ? 32'd4 : state == DECODE ? {sext[29:0], 2'b00} : (is_r || is_beq) ? rb : sext;
      alu_op = state != EXECUTE ? A_ADD : is_beq ? A_SUB : !is_r ? A_ADD :
               funct == 6'h22 ? A_SUB : funct == 6'h24 ? A_AND : funct == 6'h25 ? A_OR : funct == 6'h2A ? A_SLT : A_ADD;
      alu_y  = alu_op == A_SUB ? alu_a - alu_b : alu_op == A_AND ? alu_a & alu_b : alu_op == A_OR ? alu_a | alu_b :
               alu_op == A_SLT ? {31'd0, $signed(alu_a) < $signed(alu_b)} : alu_a + alu_b;
   end
   always_comb begin
      next_state = state;
      case (state)
         FETCH:     next_state = DECODE;
         DECODE:    next_state = legal ? EXECUTE : HALT;
         EXECUTE:   next_state = (is_lw || is_sw) ? MEMORY : (is_beq || is_j) ? FETCH : WRITEBACK;
         MEMORY:    next_state = is_lw ? WRITEBACK : FETCH;
         WRITEBACK: next_state = FETCH;
         default:   next_state = state;
      endcase
   end
   always_ff @(posedge CLK) state <= (RST || WE) ? FETCH : next_state;
   always_ff @(posedge CLK) begin
      if (WE && !RST) imem[load_ptr] <= W_Ins;
      if (run && state == MEMORY && is_sw) dmem[Result[DW+1:2]] <= rb;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         PC       <= RESET_PC;
         Result   <= '0;
         load_ptr <= '0;
         ir       <= '0;
         pc4      <= '0;
         target   <= '0;
         ra       <= '0;
         rb       <= '0;
         mdr      <= '0;
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (WE) begin
         load_ptr <= load_ptr + IW'(1);
         PC       <= RESET_PC;
      end else begin
         case (state)
            FETCH: begin
               ir  <= imem[PC[IW+1:2]];
               pc4 <= alu_y;
            end
            DECODE: begin
               ra     <= rf[ir[25:21]];
               rb     <= rf[ir[20:16]];
               target <= alu_y;
            end
            EXECUTE: begin
               Result <= alu_y;
               if (is_beq) PC <= alu_y == 32'd0 ? target : pc4;
               if (is_j) PC <= {pc4[31:28], ir[25:0], 2'b00};
            end
            MEMORY: begin
               mdr <= dmem[Result[DW+1:2]];
               if (is_sw) PC <= pc4;
            end
            WRITEBACK: begin
               PC <= pc4;
               if (dest != 5'd0) rf[dest] <= is_lw ? mdr : Result;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_mips.sv
// tb_multicycle_mips: directed program run against an instruction-level model of multicycle_mips
module tb_multicycle_mips;
   logic        CLK = 0, RST = 0, WE = 0, Done, Halt;
   logic [31:0] W_Ins = 0, PC, Result;
   int          n_cmp = 0, n_bad = 0, c = 0, r13 = 0;
   logic        go = 0;
   logic [31:0] img [256];
   logic [31:0] m_imem [256], m_dmem [256], m_regs [32];
   logic [31:0] m_pc = 0, m_res = 0, mi, ma, mb, msx, mp4, cur;
   logic [5:0]  mop;
   logic        m_known = 0, m_halt = 0;
   int          m_k = 0, m_ptr = 0;
   int          dq [$];
   multicycle_mips #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .RESET_PC(32'h0)) dut (
      .CLK(CLK), .RST(RST), .WE(WE), .W_Ins(W_Ins), .PC(PC), .Result(Result), .Done(Done), .Halt(Halt));
   always #5 CLK = ~CLK;
   function automatic logic legal_ins(input logic [31:0] i);
      logic [5:0] o = i[31:26], f = i[5:0];
      return o == 6'h00 ? (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A)
                        : (o == 6'h08 || o == 6'h23 || o == 6'h2B || o == 6'h04 || o == 6'h02);
   endfunction
   function automatic int lat_ins(input logic [31:0] i);
      logic [5:0] o = i[31:26];
      return o == 6'h23 ? 5 : (o == 6'h04 || o == 6'h02) ? 3 : 4;
   endfunction
   function automatic logic [31:0] alu_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge CLK);
      #1;
   endtask
   task automatic wait_pc(input logic [31:0] a, input string nm, output int n);
      n = 0;
      while (PC !== a && n < 400) begin
         tick();
         n++;
      end
      chk(nm, PC, a);
   endtask
   // Instruction-level model: an instruction occupies its architectural latency in cycles,
   // its ALU value appears after its third cycle, and its effects land on its last cycle.
   initial forever begin
      @(posedge CLK);
      if (RST) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 0;
         m_pc = 0; m_res = 0; m_known = 1; m_halt = 0; m_k = 0; m_ptr = 0;
      end else if (WE) begin
         m_imem[m_ptr] = W_Ins;
         m_ptr = (m_ptr + 1) % 256;
         m_pc = 0; m_halt = 0; m_k = 0;
      end else if (!m_halt) begin
         mi = m_imem[m_pc[9:2]];
         if (!legal_ins(mi)) begin
            if (m_k == 1) m_halt = 1;
            else m_k++;
         end else begin
            mop = mi[31:26];
            ma  = m_regs[mi[25:21]];
            mb  = m_regs[mi[20:16]];
            msx = {{16{mi[15]}}, mi[15:0]};
            if (m_k == 2) begin
               m_known = mop != 6'h02;
               m_res = mop == 6'h00 ? alu_r(mi[5:0], ma, mb) : mop == 6'h04 ? ma - mb : ma + msx;
            end
            if (m_k == lat_ins(mi) - 1) begin
               mp4 = m_pc + 4;
               if (mop == 6'h00 && mi[15:11] != 0) m_regs[mi[15:11]] = m_res;
               if (mop == 6'h08 && mi[20:16] != 0) m_regs[mi[20:16]] = m_res;
               if (mop == 6'h23 && mi[20:16] != 0) m_regs[mi[20:16]] = m_dmem[m_res[9:2]];
               if (mop == 6'h2B) m_dmem[m_res[9:2]] = mb;
               m_pc = mop == 6'h04 ? (ma == mb ? mp4 + (msx << 2) : mp4) : mop == 6'h02 ? {mp4[31:28], mi[25:0], 2'b00} : mp4;
               m_k = 0;
            end else m_k++;
         end
      end
   end
   initial forever begin
      @(negedge CLK);
      if (go) begin
         cur = m_imem[m_pc[9:2]];
         chk("pc", PC, m_pc);
         chk("halt", {31'd0, Halt}, {31'd0, m_halt});
         chk("done", {31'd0, Done}, {31'd0, !RST && !WE && !m_halt && legal_ins(cur) && m_k == lat_ins(cur) - 1});
         if (m_known) chk("result", Result, m_res);
      end
   end
   initial begin
      for (int i = 0; i < 256; i++) begin
         img[i] = 0; m_imem[i] = 0; m_dmem[i] = 0;
      end
      img[0] = 32'h2001_0005; img[1] = 32'h2002_0007; img[2] = 32'h0022_1820; img[3] = 32'hAC03_0008;
      img[4] = 32'h8C04_0008; img[5] = 32'h0024_282A; img[6] = 32'h008B_3020; img[7] = 32'h2007_0005;
      img[8] = 32'h1027_0002; img[9] = 32'h2009_0063; img[10] = 32'h2009_0063; img[11] = 32'h1022_0005;
      img[12] = 32'h2008_8000;
      for (int i = 13; i < 29; i++) img[i] = 32'h0108_4020;
      img[29] = 32'h200A_0001; img[30] = 32'h010A_4822; img[31] = 32'h8C0B_0008; img[32] = 32'h0BFF_FFFF;
      img[255] = 32'hFC00_0000;
      RST = 1; WE = 1; W_Ins = 32'hFFFF_FFFF;
      tick();
      go = 1; RST = 0;
      for (int i = 0; i < 4; i++) begin
         W_Ins = img[i];
         tick();
      end
      WE = 0;
      for (int k = 1; k <= 16; k++) begin
         if (Done) dq.push_back(k);
         if (k == 13) r13 = Result;
         tick();
      end
      chk("done_pulses", dq.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("done_at_%0d", i), i < dq.size() ? dq[i] : 0, 4 * (i + 1));
      chk("add_result", r13, 12);
      chk("sw_addr_result", Result, 8);
      chk("burst_pc", PC, 32'h10);
      chk("model_dmem2", m_dmem[2], 12);
      WE = 1;
      for (int i = 4; i < 256; i++) begin
         W_Ins = img[i];
         tick();
      end
      WE = 0;
      wait_pc(32'h10, "lw_fetch", c);
      wait_pc(32'h14, "lw_next", c);
      chk("lw_cycles", c, 5);
      wait_pc(32'h18, "slt_next", c);
      chk("slt_result", Result, 1);
      wait_pc(32'h1C, "add6_next", c);
      chk("add6_result", Result, 12);
      chk("model_r4", m_regs[4], 12);
      wait_pc(32'h20, "beq_fetch", c);
      wait_pc(32'h2C, "beq_taken_pc", c);
      chk("beq_taken_cycles", c, 3);
      wait_pc(32'h30, "beq_nt_pc", c);
      chk("beq_nt_cycles", c, 3);
      chk("beq_nt_result", Result, 32'hFFFF_FFFE);
      wait_pc(32'h7C, "sub_next", c);
      chk("sub_result", Result, 32'h7FFF_FFFF);
      chk("sub_no_halt", {31'd0, Halt}, 0);
      wait_pc(32'h0FFF_FFFC, "j_target", c);
      tick();
      tick();
      chk("halt_set", {31'd0, Halt}, 1);
      repeat (3) tick();
      chk("halt_pc_frozen", PC, 32'h0FFF_FFFC);
      chk("halt_no_done", {31'd0, Done}, 0);
      WE = 1; W_Ins = img[0];
      tick();
      WE = 0;
      chk("halt_cleared", {31'd0, Halt}, 0);
      chk("restart_pc", PC, 32'h0);
      wait_pc(32'h08, "add3_fetch", c);
      tick();
      tick();
      RST = 1;
      tick();
      chk("rst_pc", PC, 32'h0);
      chk("rst_result", Result, 32'h0);
      chk("rst_done", {31'd0, Done}, 0);
      chk("rst_halt", {31'd0, Halt}, 0);
      RST = 0;
      wait_pc(32'h0C, "rerun_sw_fetch", c);
      chk("rerun_result", Result, 12);
      wait_pc(32'h7C, "lw11_fetch", c);
      repeat (3) tick();
      WE = 1; W_Ins = img[0];
      tick();
      WE = 0;
      chk("model_r11", m_regs[11], 0);
      wait_pc(32'h1C, "abort_add6_next", c);
      chk("abort_r11_result", Result, 12);
      repeat (5) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
